// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side (ports A and B) and mem_ctrl-side signals of
// mem_arbiter. The slave modport is the arbiter's view; master is the view of
// whatever drives the requests and models mem_ctrl.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // port A: instruction fetch, read-only
  logic              I_a_req;
  logic [ADDR_W-1:0] I_a_addr;
  logic              O_a_ack;
  // port B: load/store
  logic              I_b_req;
  logic              I_b_write;
  logic [ADDR_W-1:0] I_b_addr;
  logic [DATA_W-1:0] I_b_wdata;
  logic              O_b_ack;
  // shared response
  logic [DATA_W-1:0] O_rdata;
  logic              O_err;
  // mem_ctrl request stream
  logic              O_exec;
  logic              O_write;
  logic [ADDR_W-1:0] O_addr;
  logic [DATA_W-1:0] O_wdata;
  logic              I_ready;
  logic [DATA_W-1:0] I_rdata;

  modport slave (
    input  I_a_req, I_a_addr, I_b_req, I_b_write, I_b_addr, I_b_wdata,
           I_ready, I_rdata,
    output O_a_ack, O_b_ack, O_rdata, O_err, O_exec, O_write, O_addr, O_wdata
  );

  modport master (
    output I_a_req, I_a_addr, I_b_req, I_b_write, I_b_addr, I_b_wdata,
           I_ready, I_rdata,
    input  O_a_ack, O_b_ack, O_rdata, O_err, O_exec, O_write, O_addr, O_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of mem_ctrl. Port A (fetch, read-only) and port B
// (load/store) share a single exec/write/addr/data request stream; one
// transaction is outstanding at a time, and a watchdog aborts transactions
// that mem_ctrl never finishes.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise port B has fixed priority over port A.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255   // max WAIT cycles before abort, 0 disables
) (
  input  logic           I_clk,
  input  logic           I_reset,
  mem_arbiter_if.slave   bus
);

  // Watchdog needs at least one bit even when it is disabled.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {PORT_A, PORT_B} port_e;

  state_e            state_q, state_d;
  port_e             grant_q, grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q,   err_d;
  logic [WD_W-1:0]   wd_q,    wd_d;
  logic [WD_W-1:0]   wd_inc;
  logic              win_b;

  // Saturating increment: the watchdog never wraps back to zero.
  assign wd_inc = (&wd_q) ? wd_q : wd_q + WD_W'(1);

`ifdef MEM_ARB_RR_EN
  logic last_b_q, last_b_d;

  // On a tie, grant the port that was not served last.
  assign win_b = bus.I_b_req && (!bus.I_a_req || !last_b_q);

  // Remember which port completed, updated as the transaction retires.
  always_comb begin
    last_b_d = last_b_q;
    if (state_q == DONE) last_b_d = (grant_q == PORT_B);
  end

  // Last-served flag register; port A counts as last served after reset.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) last_b_q <= 1'b0;
    else         last_b_q <= last_b_d;
  end
`else
  // Fixed priority: B wins whenever it requests; A can starve.
  assign win_b = bus.I_b_req;
`endif

  // Next-state and datapath capture for the IDLE->ISSUE->WAIT->DONE sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if ((bus.I_a_req || bus.I_b_req) && bus.I_ready) begin
          err_d = 1'b0;
          if (win_b) begin
            grant_d = PORT_B;
            write_d = bus.I_b_write;
            addr_d  = bus.I_b_addr;
            wdata_d = bus.I_b_wdata;
          end else begin
            grant_d = PORT_A;
            write_d = 1'b0;
            addr_d  = bus.I_a_addr;
          end
          state_d = ISSUE;
        end
      end
      // I_ready is not looked at here: mem_ctrl drops it while exec is high.
      ISSUE: state_d = WAIT;
      WAIT: begin
        wd_d = wd_inc;
        // wd_q == 0 marks the first WAIT cycle, which never completes.
        if ((wd_q != '0) && bus.I_ready) begin
          if (!write_q) rdata_d = bus.I_rdata;
          state_d = DONE;
        end else if ((TIMEOUT != 0) && (wd_inc == WD_W'(TIMEOUT))) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        wd_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers with asynchronous reset.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= IDLE;
      grant_q <= PORT_B;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  // Strobes decode the state register, so reset removes them immediately.
  assign bus.O_exec  = (state_q == ISSUE);
  assign bus.O_a_ack = (state_q == DONE) && (grant_q == PORT_A);
  assign bus.O_b_ack = (state_q == DONE) && (grant_q == PORT_B);
  assign bus.O_err   = (state_q == DONE) && err_q;
  assign bus.O_write = write_q;
  assign bus.O_addr  = addr_q;
  assign bus.O_wdata = wdata_q;
  assign bus.O_rdata = rdata_q;

endmodule
